// File: rtl/pong_pkg.sv
// Shared definitions for the score-to-BCD scheduling logic.
//   sched_state_t : scheduler FSM encoding (FLUSH / ARB / START / WAIT)
//   bcd_max()     : largest value representable in n_digits BCD digits
package pong_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,  // converter drain period, no start pulses issued
    ARB   = 2'd1,  // idle / picking the next requester
    START = 2'd2,  // one-cycle start pulse to the converter
    WAIT  = 2'd3   // waiting for conv_completed or timeout
  } sched_state_t;

  // 10^n_digits - 1, e.g. 99 for two digits.
  function automatic int bcd_max(input int n_digits);
    int m;
    m = 1;
    for (int i = 0; i < n_digits; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

endpackage

// File: rtl/score_bcd_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   pending     : in  request vector
//   ptr         : in  highest-priority index for this pick
//   grant_idx   : out first set bit of pending at or after ptr (with wrap)
//   grant_valid : out pending is nonzero
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  // Rotate pending so that bit ptr lands at position 0; the first set bit
  // of the rotated vector is then the offset from ptr to the winner.
  assign doubled = {pending, pending} >> ptr;
  assign rotated = doubled[N_REQ-1:0];

  always_comb begin
    offset      = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_valid && rotated[k]) begin
        grant_valid = 1'b1;
        offset      = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(N_REQ)) begin
      sum = sum - (IDX_W + 1)'(N_REQ);
    end
    grant_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Shares one BinaryToBCD converter between N_REQ score sources.
//   clock, reset   : clock / async active-high reset
//   req, value     : per-requester request pulse and binary score
//   conv_start, conv_binary, conv_bcd, conv_completed : converter handshake
//   bcd_out, upd   : last BCD result per requester and its refresh pulse
//   busy           : high whenever the scheduler is not idle in ARB
//   timeout_err    : pulse when a conversion is abandoned
// Requests are latched into a pending mask and served round-robin. The
// value is sampled when the grant is made, saturated to the BCD range.
module score_bcd_scheduler #(
  parameter int N_REQ        = 2,
  parameter int INPUT_LENGTH = 8,
  parameter int N_DIGITS     = 2,
  parameter int TIMEOUT      = 255,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*INPUT_LENGTH-1:0]   value,
  output logic                            conv_start,
  output logic [INPUT_LENGTH-1:0]         conv_binary,
  input  logic [N_DIGITS*4-1:0]           conv_bcd,
  input  logic                            conv_completed,
  output logic [N_REQ*N_DIGITS*4-1:0]     bcd_out,
  output logic [N_REQ-1:0]                upd,
  output logic                            busy,
  output logic                            timeout_err
);
  import pong_pkg::*;

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCD_W   = N_DIGITS * 4;
  localparam int MAX_VAL = bcd_max(N_DIGITS);
  localparam int FL_W    = $clog2(FLUSH_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [63:0] MAX_64 = 64'(MAX_VAL);

  sched_state_t              state_q, state_d;
  logic [FL_W-1:0]           flush_cnt_q, flush_cnt_d;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [N_REQ-1:0]          pending_q, pending_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d;
  logic                      conv_start_q, conv_start_d;
  logic [INPUT_LENGTH-1:0]   conv_binary_q, conv_binary_d;
  logic [BCD_W-1:0]          bcd_q [N_REQ];
  logic [BCD_W-1:0]          bcd_d [N_REQ];
  logic [N_REQ-1:0]          upd_q, upd_d;
  logic                      busy_q, busy_d;
  logic                      timeout_err_q, timeout_err_d;

  logic [INPUT_LENGTH-1:0]   value_slice [N_REQ];
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;
  logic [N_REQ-1:0]          pending_clr;
  logic [INPUT_LENGTH-1:0]   sel_value;
  logic [INPUT_LENGTH-1:0]   sat_value;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign value_slice[gi]                = value[gi*INPUT_LENGTH +: INPUT_LENGTH];
      assign bcd_out[gi*BCD_W +: BCD_W]     = bcd_q[gi];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Values above the BCD range are clamped to all-nines.
  always_comb begin
    sel_value = value_slice[arb_idx];
    sat_value = sel_value;
    if (64'(sel_value) > MAX_64) begin
      sat_value = INPUT_LENGTH'(MAX_VAL);
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    conv_binary_d = conv_binary_q;
    bcd_d         = bcd_q;
    upd_d         = '0;
    timeout_err_d = 1'b0;
    pending_clr   = '0;

    case (state_q)
      FLUSH: begin
        // conv_completed is deliberately ignored: it may belong to a
        // conversion started before reset or before a timeout.
        if (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1)) begin
          state_d = ARB;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      ARB: begin
        if (arb_valid) begin
          pending_clr   = N_REQ'(1) << arb_idx;
          gnt_d         = arb_idx;
          ptr_d         = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          conv_binary_d = sat_value;
          state_d       = START;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (conv_completed) begin
          bcd_d[gnt_q] = conv_bcd;
          upd_d        = N_REQ'(1) << gnt_q;
          state_d      = ARB;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 2)) begin
          // The registered pulse lands exactly TIMEOUT cycles after the
          // start pulse (counter is 0 in the first WAIT cycle).
          timeout_err_d = 1'b1;
          flush_cnt_d   = '0;
          state_d       = FLUSH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        flush_cnt_d = '0;
        state_d     = FLUSH;
      end
    endcase

    // A request arriving in its own grant cycle survives the clear.
    pending_d    = (pending_q & ~pending_clr) | req;
    conv_start_d = (state_d == START);
    busy_d       = (state_d != ARB);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FLUSH;
      flush_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      pending_q     <= '0;
      ptr_q         <= '0;
      gnt_q         <= '0;
      conv_start_q  <= 1'b0;
      conv_binary_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        bcd_q[i] <= '0;
      end
      upd_q         <= '0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      conv_start_q  <= conv_start_d;
      conv_binary_q <= conv_binary_d;
      bcd_q         <= bcd_d;
      upd_q         <= upd_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign conv_start  = conv_start_q;
  assign conv_binary = conv_binary_q;
  assign upd         = upd_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
Shares one BinaryToBCD converter between N_REQ score sources (default two Pong players). Latches per-requester conversion requests and grants them round-robin. Drives the converter's start/binary/completed handshake and holds the last BCD result per requester for the seven-segment/score display logic. Sits between the game-logic score counters and the display driver.

Parameters:
N_REQ, 2, number of requesters sharing the converter (2..8)
INPUT_LENGTH, 8, binary width per requester; must match converter INPUT_LENGTH
N_DIGITS, 2, BCD digits per result; must match converter N_DIGITS
TIMEOUT, 255, max cycles to wait for conv_completed before abandoning a conversion
FLUSH_CYCLES, 64, post-reset quiet period; must exceed worst-case converter latency (46 cycles at defaults)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request pulse; bit i sets pending[i]
value  in  N_REQ*INPUT_LENGTH  binary value of requester i at [i*INPUT_LENGTH+:INPUT_LENGTH]
conv_start  out  1  start pulse to converter
conv_binary  out  INPUT_LENGTH  operand to converter
conv_bcd  in  N_DIGITS*4  converter result
conv_completed  in  1  converter one-cycle done pulse
bcd_out  out  N_REQ*N_DIGITS*4  registered result of requester i at [i*N_DIGITS*4+:N_DIGITS*4]
upd  out  N_REQ  one-cycle pulse: bcd_out slice i refreshed
busy  out  1  high whenever state is not ARB
timeout_err  out  1  one-cycle pulse when a conversion is abandoned

Behaviour:
- Reset (async assert, sync release): state=FLUSH, flush counter=0, pending=0, rr pointer=0, conv_start=0, conv_binary=0, bcd_out=0, upd=0, busy=1, timeout_err=0.
- The converter has no reset and may still be mid-conversion after our reset. FLUSH holds conv_start=0 for FLUSH_CYCLES cycles and ignores conv_completed. It then enters ARB. req pulses arriving during FLUSH are still latched into pending.
- pending[i] is set on any cycle with req[i]=1 and cleared only when requester i is granted. If set and clear occur in the same cycle, set wins, so requester i is reconverted later.
- ARB: if pending is nonzero, grant the first set bit at or after rr pointer, searching upward with wrap. Clear that pending bit, latch grant index g, set rr pointer to (g+1) mod N_REQ, go to START. If pending is zero, stay in ARB.
- value is sampled in the ARB grant cycle, not at req time.
- Saturation: MAX = 10^N_DIGITS-1. If the sampled value exceeds MAX, conv_binary is loaded with MAX (99 at defaults). Otherwise it is loaded unchanged.
- START: conv_start=1 for exactly this one cycle, with conv_binary stable. Next state is WAIT, with the timeout counter cleared.
- WAIT: conv_binary is held and conv_start=0.
  - On conv_completed=1: capture conv_bcd into bcd_out slice g, pulse upd[g] in the following cycle, return to ARB.
  - Otherwise, if the timeout counter reaches TIMEOUT: pulse timeout_err, leave bcd_out unchanged, return to FLUSH to let the converter drain.
- conv_completed outside WAIT is ignored.
- Throughput: one conversion per converter latency + 3 cycles. No back-to-back start pulses.
- Only one upd bit is high in any cycle. upd and timeout_err are never high together.
- All outputs are registered.

Decomposition:
- Shared package (pong_pkg): function computing MAX from N_DIGITS; state encoding localparams FLUSH/ARB/START/WAIT.
- One natural sub-module: rr_arbiter (N_REQ-wide round-robin priority pick returning grant index and valid; combinational with pointer input). Pointer register stays in score_bcd_scheduler.
- Testbench instantiates the real BinaryToBCD alongside the scheduler.

Test Plan:
1. Reset, then req[0] pulse at FLUSH_CYCLES+5 with value0=42 -> one conv_start; bcd_out[7:0]=0x42; upd=2'b01 for one cycle; busy back low.
2. req=2'b11 in the same cycle, value0=7, value1=93 -> player 0 converted first, then player 1; bcd_out=0x9307; two single upd pulses in order 01, 10.
3. value1=150, req[1] -> conv_binary=99; bcd_out[15:8]=0x99.
4. req[0] re-pulsed while player 0 is in WAIT; value0 changed 12 to 13 during WAIT -> first result 0x12, second conversion follows with result 0x13.
5. Converter stub never asserts conv_completed -> timeout_err pulse exactly TIMEOUT cycles after START; bcd_out unchanged; FLUSH re-entered; later request succeeds.
6. Reset asserted mid-conversion -> outputs reset immediately; late conv_completed during FLUSH ignored; next request after FLUSH converts correctly.
